// File: rtl/sntc_ldpc_iter_pkg.sv
// sntc_ldpc_iter_pkg: shared types and constants for the LDPC iteration controller
package sntc_ldpc_iter_pkg;
    localparam int SUM_LEN_DEF  = 32;
    localparam int IIR_FRAC_DEF = 8;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, EVAL, DONE} iter_state_t;

    typedef struct packed {
        logic                   pass_fail;
        logic                   loops_ended;
        logic [SUM_LEN_DEF-1:0] loop_cnt;
    } result_t;
endpackage

// File: rtl/sntc_ldpc_popcount.sv
// sntc_ldpc_popcount: combinational Hamming distance between two syndromes
module sntc_ldpc_popcount #(
    parameter int W  = 168,
    parameter int OW = 32
) (
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic [OW-1:0] cnt
);
    logic [W-1:0] x;

    assign x = a ^ b;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < W; i++) cnt = cnt + OW'(x[i]);
    end
endmodule

// File: rtl/sntc_ldpc_iter_ctrl.sv
// sntc_ldpc_iter_ctrl: launches decode iterations and ends on pass, loop limit or stall.
// SNTC_HAMDIST_IIR_EN switches the stall check to an IIR-filtered distance.
module sntc_ldpc_iter_ctrl
    import sntc_ldpc_iter_pkg::*;
#(
    parameter int MM      = 168,
    parameter int SUM_LEN = SUM_LEN_DEF
`ifdef SNTC_HAMDIST_IIR_EN
    , parameter int IIR_FRAC = IIR_FRAC_DEF
`endif
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               clr,
    input  logic               start_dec,
    input  logic [MM-1:0]      exp_syn,
    input  logic [MM-1:0]      cur_syndrome,
    input  logic               syn_valid,
    input  logic [SUM_LEN-1:0] loop_max,
    input  logic [SUM_LEN-1:0] stall_max,
`ifdef SNTC_HAMDIST_IIR_EN
    input  logic [3:0]         iir_shift,
`endif
    output logic               iter_start,
    output logic               busy,
    output logic [SUM_LEN-1:0] hamdist,
    output logic [SUM_LEN-1:0] best_hamdist,
    output logic [SUM_LEN-1:0] loop_cnt,
    output logic               loops_ended,
    output logic               pass_fail,
    output logic               done
);
    iter_state_t        state, nxt;
    logic [SUM_LEN-1:0] pc, stall, lc_new, st_new, lmax;
    logic               improve, pass, lim, stl, fin;

    sntc_ldpc_popcount #(.W(MM), .OW(SUM_LEN)) u_pc (.a(exp_syn), .b(cur_syndrome), .cnt(pc));

`ifdef SNTC_HAMDIST_IIR_EN
    localparam int FW = SUM_LEN + IIR_FRAC;
    logic [FW-1:0]      f, f_new, hdx;
    logic signed [FW:0] diff;

    assign hdx     = {hamdist, {IIR_FRAC{1'b0}}};
    assign diff    = $signed({1'b0, hdx}) - $signed({1'b0, f});
    // first evaluation of a decode seeds the filter instead of stepping it
    assign f_new   = (loop_cnt == '0) ? hdx : FW'($signed({1'b0, f}) + (diff >>> iir_shift));
    assign improve = (loop_cnt == '0) || (f_new < f);
`else
    assign improve = hamdist < best_hamdist;
`endif

    assign lc_new = &loop_cnt ? loop_cnt : loop_cnt + SUM_LEN'(1);
    assign st_new = improve ? '0 : (&stall ? stall : stall + SUM_LEN'(1));
    assign lmax   = (loop_max == '0) ? SUM_LEN'(1) : loop_max;
    assign pass   = hamdist == '0;
    assign lim    = lc_new >= lmax;
    assign stl    = (stall_max != '0) && (st_new >= stall_max);
    assign fin    = pass || lim || stl;

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= IDLE;
        else       state <= clr ? IDLE : nxt;

    always_comb begin
        nxt = (state == IDLE)   ? (start_dec ? LAUNCH : IDLE) :
              (state == LAUNCH) ? WAIT :
              (state == WAIT)   ? (syn_valid ? EVAL : WAIT) :
              (state == EVAL)   ? (fin ? DONE : LAUNCH) : IDLE;
    end

    always_comb begin
        iter_start = state == LAUNCH;
        busy       = state != IDLE;
        done       = state == DONE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hamdist      <= '0;
            best_hamdist <= '0;
            loop_cnt     <= '0;
            stall        <= '0;
            loops_ended  <= 1'b0;
            pass_fail    <= 1'b0;
`ifdef SNTC_HAMDIST_IIR_EN
            f            <= '0;
`endif
        end else if (clr) begin
            hamdist      <= '0;
            best_hamdist <= '0;
            loop_cnt     <= '0;
            stall        <= '0;
            loops_ended  <= 1'b0;
            pass_fail    <= 1'b0;
`ifdef SNTC_HAMDIST_IIR_EN
            f            <= '0;
`endif
        end else begin
            if (state == IDLE && start_dec) begin
                hamdist      <= '0;
                best_hamdist <= '1;
                loop_cnt     <= '0;
                stall        <= '0;
                loops_ended  <= 1'b0;
                pass_fail    <= 1'b0;
            end
            if (state == WAIT && syn_valid) hamdist <= pc;
            if (state == EVAL) begin
                loop_cnt     <= lc_new;
                best_hamdist <= (hamdist < best_hamdist) ? hamdist : best_hamdist;
                stall        <= st_new;
                pass_fail    <= pass;
                loops_ended  <= !pass && (lim || stl);
`ifdef SNTC_HAMDIST_IIR_EN
                f            <= f_new;
`endif
            end
        end
    end
endmodule

// File: tb/tb_sntc_ldpc_iter_ctrl.sv
// tb_sntc_ldpc_iter_ctrl: randomized decodes checked against a rule-level model of the controller
module tb_sntc_ldpc_iter_ctrl;
    localparam int MM = 168;
    localparam int SL = 32;

    logic          clk = 1'b0, rstn = 1'b0, clr = 1'b0, start_dec = 1'b0, syn_valid = 1'b0;
    logic [MM-1:0] exp_syn = '0, cur_syndrome = '0;
    logic [SL-1:0] loop_max = '0, stall_max = '0;
`ifdef SNTC_HAMDIST_IIR_EN
    logic [3:0]    iir_shift = 4'd2;
`endif
    logic          iter_start, busy, loops_ended, pass_fail, done;
    logic [SL-1:0] hamdist, best_hamdist, loop_cnt;

    int n_cmp = 0, n_err = 0;
    int hd_q[$];

    always #5 clk = ~clk;

    sntc_ldpc_iter_ctrl #(.MM(MM), .SUM_LEN(SL)) dut (
        .clk(clk), .rstn(rstn), .clr(clr), .start_dec(start_dec),
        .exp_syn(exp_syn), .cur_syndrome(cur_syndrome), .syn_valid(syn_valid),
        .loop_max(loop_max), .stall_max(stall_max),
`ifdef SNTC_HAMDIST_IIR_EN
        .iir_shift(iir_shift),
`endif
        .iter_start(iter_start), .busy(busy), .hamdist(hamdist), .best_hamdist(best_hamdist),
        .loop_cnt(loop_cnt), .loops_ended(loops_ended), .pass_fail(pass_fail), .done(done)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic new_exp();
        for (int i = 0; i < MM; i++) exp_syn[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic mk_cur(input int hd);
        logic [MM-1:0] m;
        m = '0;
        while ($countones(m) < hd) m[$urandom_range(0, MM - 1)] = 1'b1;
        cur_syndrome = exp_syn ^ m;
    endtask

    task automatic wait_iter(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (iter_start) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL iter_start_timeout got=0 want=1"); end
    endtask

    task automatic run_decode(input int lmax, input int smax, input bit poke);
        bit ok, fin, pass, lim, st;
        int hd, hd_exp, lm, m_loop, m_stall;
        logic [SL-1:0] m_best;
        loop_max = SL'(lmax);
        stall_max = SL'(smax);
        new_exp();
        start_dec = 1'b1;
        @(negedge clk);
        start_dec = 1'b0;
        wait_iter(ok);
        if (!ok) return;
        n_cmp++; if (loop_cnt !== '0) begin n_err++; $display("FAIL launch_loop_cnt got=%0d want=0", loop_cnt); end
        n_cmp++; if (best_hamdist !== '1) begin n_err++; $display("FAIL launch_best got=%0h want=ffffffff", best_hamdist); end
        n_cmp++; if (hamdist !== '0) begin n_err++; $display("FAIL launch_hamdist got=%0d want=0", hamdist); end
        n_cmp++; if ({pass_fail, loops_ended} !== 2'b00) begin n_err++; $display("FAIL launch_flags got=%b want=00", {pass_fail, loops_ended}); end
        m_loop = 0; m_stall = 0; m_best = '1; fin = 1'b0;
        lm = (lmax == 0) ? 1 : lmax;
        while (!fin) begin
            @(negedge clk);
            n_cmp++; if (iter_start !== 1'b0) begin n_err++; $display("FAIL iter_start_pulse got=%b want=0", iter_start); end
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_wait got=%b want=1", busy); end
            repeat ($urandom_range(poke ? 1 : 0, 2)) begin
                start_dec = poke;
                @(negedge clk);
                start_dec = 1'b0;
            end
            hd = (hd_q.size() != 0) ? hd_q.pop_front() : int'($urandom_range(1, 30));
            mk_cur(hd);
            hd_exp = $countones(exp_syn ^ cur_syndrome);
            syn_valid = 1'b1;
            @(negedge clk);
            syn_valid = 1'b0;
            cur_syndrome = ~cur_syndrome;
            n_cmp++; if (hamdist !== SL'(hd_exp)) begin n_err++; $display("FAIL hamdist got=%0d want=%0d", hamdist, hd_exp); end
            n_cmp++; if ({done, iter_start} !== 2'b00) begin n_err++; $display("FAIL eval_quiet got=%b want=00", {done, iter_start}); end
            m_loop++;
            if (SL'(hd_exp) < m_best) begin m_best = SL'(hd_exp); m_stall = 0; end
            else m_stall++;
            pass = hd_exp == 0;
            lim = m_loop >= lm;
            st = (smax != 0) && (m_stall >= smax);
            fin = pass || lim || st;
            @(negedge clk);
            n_cmp++; if (loop_cnt !== SL'(m_loop)) begin n_err++; $display("FAIL loop_cnt got=%0d want=%0d", loop_cnt, m_loop); end
            n_cmp++; if (best_hamdist !== m_best) begin n_err++; $display("FAIL best_hamdist got=%0d want=%0d", best_hamdist, m_best); end
            if (fin) begin
                n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL done_latency got=%b want=1", done); end
                n_cmp++; if (pass_fail !== pass) begin n_err++; $display("FAIL pass_fail got=%b want=%b", pass_fail, pass); end
                n_cmp++; if (loops_ended !== !pass) begin n_err++; $display("FAIL loops_ended got=%b want=%b", loops_ended, !pass); end
                @(negedge clk);
                n_cmp++; if ({done, busy, iter_start} !== 3'b000) begin n_err++; $display("FAIL after_done got=%b want=000", {done, busy, iter_start}); end
                n_cmp++; if ({pass_fail, loops_ended} !== {pass, !pass}) begin n_err++; $display("FAIL held_flags got=%b want=%b", {pass_fail, loops_ended}, {pass, !pass}); end
                n_cmp++; if (loop_cnt !== SL'(m_loop)) begin n_err++; $display("FAIL held_loop_cnt got=%0d want=%0d", loop_cnt, m_loop); end
            end else begin
                n_cmp++; if ({iter_start, done} !== 2'b10) begin n_err++; $display("FAIL relaunch got=%b want=10", {iter_start, done}); end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if ({iter_start, busy, done, pass_fail, loops_ended} !== 5'b0) begin n_err++; $display("FAIL reset_flags got=%b want=00000", {iter_start, busy, done, pass_fail, loops_ended}); end
        n_cmp++; if ({hamdist, best_hamdist, loop_cnt} !== '0) begin n_err++; $display("FAIL reset_counts got=%0d/%0d/%0d want=0/0/0", hamdist, best_hamdist, loop_cnt); end
        rstn = 1'b1;
        @(negedge clk);
        n_cmp++; if ({busy, iter_start, best_hamdist} !== '0) begin n_err++; $display("FAIL idle_after_reset got=%b/%b/%0d want=0/0/0", busy, iter_start, best_hamdist); end
    endtask

    task automatic test_spec_cases();
        hd_q = {0};       run_decode(10, 0, 0);
        hd_q = {5, 4, 3}; run_decode(3, 0, 0);
        hd_q = {7, 7, 7}; run_decode(20, 2, 0);
        hd_q = {4};       run_decode(0, 0, 0);
    endtask

    task automatic test_ignore();
        bit bad;
        hd_q = {6, 2};
        run_decode(2, 0, 1);
        mk_cur(9);
        syn_valid = 1'b1;
        @(negedge clk);
        syn_valid = 1'b0;
        bad = 1'b0;
        repeat (2) begin
            if (iter_start || busy || done || loop_cnt !== SL'(2) || hamdist !== SL'(2)) bad = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (bad) begin n_err++; $display("FAIL idle_syn_valid got=changed want=unchanged (lc=%0d hd=%0d)", loop_cnt, hamdist); end
    endtask

    task automatic test_abort(input bit use_clr);
        bit ok, seen;
        loop_max = SL'(10);
        stall_max = '0;
        new_exp();
        start_dec = 1'b1;
        @(negedge clk);
        start_dec = 1'b0;
        wait_iter(ok);
        @(negedge clk);
        mk_cur(5);
        syn_valid = 1'b1;
        @(negedge clk);
        syn_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (iter_start !== 1'b1) begin n_err++; $display("FAIL abort_relaunch got=%b want=1", iter_start); end
        @(negedge clk);
        if (use_clr) begin
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
        end else begin
            rstn = 1'b0;
            #1;
        end
        n_cmp++; if ({busy, iter_start, done, pass_fail, loops_ended} !== 5'b0) begin n_err++; $display("FAIL abort_flags got=%b want=00000", {busy, iter_start, done, pass_fail, loops_ended}); end
        n_cmp++; if ({hamdist, best_hamdist, loop_cnt} !== '0) begin n_err++; $display("FAIL abort_counts got=%0d/%0d/%0d want=0/0/0", hamdist, best_hamdist, loop_cnt); end
        if (!use_clr) begin
            @(negedge clk);
            rstn = 1'b1;
        end
        seen = 1'b0;
        repeat (4) begin
            if (done || busy) seen = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (seen) begin n_err++; $display("FAIL abort_no_done got=active want=idle"); end
        hd_q = {0};
        run_decode(10, 0, 0);
    endtask

    task automatic test_random();
        repeat (25) begin
            hd_q = {};
            repeat (6) hd_q.push_back(int'($urandom_range(0, 8)));
            run_decode(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_spec_cases();
        test_ignore();
        test_abort(1'b1);
        test_abort(1'b0);
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
